q1q2_skid: RTL and testbench

//  Instruction-fetch to decode pipeline register (Q1->Q2), with stall, flush and a one-entry skid buffer.
//  The instruction memory is synchronous: data returns one cycle after the request.
//  A word already in flight when decode stalls is parked in the skid entry, so it is neither lost nor refetched.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/q1q2_skid.sv | 93 +++++++++
 tb/tb_q1q2_skid.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width, the bubble instruction
// and the fetch packet carried between fetch and decode.
package riscv_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_incr;
      logic [31:0]     instr;
   } fetch_pkt_t;

endpackage

// File: rtl/q1q2_skid.sv
// Q1->Q2 pipeline register between instruction fetch and decode, with stall,
// flush, a saturating bubble counter and a one-entry skid buffer.
module q1q2_skid
   import riscv_pkg::*;
#(
   parameter int          CNT_WIDTH = 16,
   parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [XLEN-1:0]      pc_ip,
   input  logic [XLEN-1:0]      pc_incr_ip,
   input  logic [31:0]          instr_ip,
   input  logic                 fetch_valid_ip,
   output logic                 fetch_ready_op,
   input  logic                 stall_ip,
   input  logic                 flush_ip,
   output logic [XLEN-1:0]      pc_op,
   output logic [XLEN-1:0]      pc_incr_op,
   output logic [31:0]          instr_op,
   output logic                 valid_op,
   output logic [CNT_WIDTH-1:0] bubble_cnt_op
);

   // Handshake: a fetch word transfers on a posedge where fetch_valid_ip and
   // fetch_ready_op are both high; fetch_ready_op only depends on skid state,
   // never on fetch_valid_ip, and valid without ready is an upstream error.
   fetch_pkt_t           main_q;
   fetch_pkt_t           skid_q;
   logic                 valid_q;
   logic                 skid_full;
   logic [CNT_WIDTH-1:0] cnt_q;
   fetch_pkt_t           in_pkt;
   fetch_pkt_t           bubble_pkt;
   fetch_pkt_t           flush_pkt;
   logic                 accept;
   logic [CNT_WIDTH-1:0] cnt_inc;

   assign fetch_ready_op = ~skid_full;
   assign accept         = fetch_valid_ip & ~skid_full;

   assign in_pkt     = '{pc: pc_ip, pc_incr: pc_incr_ip, instr: instr_ip};
   assign bubble_pkt = '{pc: pc_ip, pc_incr: pc_incr_ip, instr: NOP_INSTR};
   assign flush_pkt  = '{pc: '0, pc_incr: '0, instr: NOP_INSTR};

   assign cnt_inc = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         main_q    <= flush_pkt;
         valid_q   <= 1'b0;
         skid_q    <= '0;
         skid_full <= 1'b0;
         cnt_q     <= '0;
      end else if (flush_ip) begin
         // Anything accepted this cycle is wrong-path and simply not stored.
         main_q    <= flush_pkt;
         valid_q   <= 1'b0;
         skid_full <= 1'b0;
         cnt_q     <= cnt_inc;
      end else if (stall_ip) begin
         if (accept) begin
            skid_q    <= in_pkt;
            skid_full <= 1'b1;
         end
      end else if (skid_full) begin
         main_q    <= skid_q;
         valid_q   <= 1'b1;
         skid_full <= 1'b0;
      end else if (accept) begin
         main_q  <= in_pkt;
         valid_q <= 1'b1;
      end else begin
         main_q  <= bubble_pkt;
         valid_q <= 1'b0;
         cnt_q   <= cnt_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(fetch_valid_ip && skid_full))
            else $error("q1q2_skid: fetch_valid_ip while fetch_ready_op low, word dropped");
      end
   end

   assign pc_op         = main_q.pc;
   assign pc_incr_op    = main_q.pc_incr;
   assign instr_op      = main_q.instr;
   assign valid_op      = valid_q;
   assign bubble_cnt_op = cnt_q;

endmodule

// File: tb/tb_q1q2_skid.sv
// Directed bench for q1q2_skid: the driver pushes each expected Q2 word with
// its arrival cycle; a negedge monitor pops and compares every new Q2 load.
module tb_q1q2_skid;

   localparam int          XLEN = 32;
   localparam int          CW   = 4;
   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam int          EW   = 16 + 2 * XLEN + 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [XLEN-1:0] pc_ip = '0;
   logic [XLEN-1:0] pc_incr_ip = '0;
   logic [31:0]     instr_ip = '0;
   logic            fetch_valid_ip = 1'b0;
   logic            fetch_ready_op;
   logic            stall_ip = 1'b0;
   logic            flush_ip = 1'b0;
   logic [XLEN-1:0] pc_op;
   logic [XLEN-1:0] pc_incr_op;
   logic [31:0]     instr_op;
   logic            valid_op;
   logic [CW-1:0]   bubble_cnt_op;

   logic [EW-1:0]   exp_q[$];
   logic [15:0]     cyc = '0;
   logic            prev_hold = 1'b0;
   int              n_tests = 0;
   int              n_fail  = 0;

   q1q2_skid #(.CNT_WIDTH(CW), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst),
      .pc_ip(pc_ip), .pc_incr_ip(pc_incr_ip), .instr_ip(instr_ip),
      .fetch_valid_ip(fetch_valid_ip), .fetch_ready_op(fetch_ready_op),
      .stall_ip(stall_ip), .flush_ip(flush_ip),
      .pc_op(pc_op), .pc_incr_op(pc_incr_op), .instr_op(instr_op),
      .valid_op(valid_op), .bubble_cnt_op(bubble_cnt_op)
   );

   // clock / cycle bookkeeping
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc       <= cyc + 16'd1;
      prev_hold <= !rst && stall_ip && !flush_ip;
   end

   // monitor: every fresh valid Q2 load must match the head of the queue
   always @(negedge clk) begin
      logic [EW-1:0] act;
      logic [EW-1:0] e;
      if (!rst && valid_op && !prev_hold) begin
         act = {cyc, pc_op, pc_incr_op, instr_op};
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_word act=%h req=none", act);
         end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
               n_fail++;
               $display("FAIL q2_word act=%h req=%h", act, e);
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s act=%h req=%h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic [31:0] ins,
                        input logic st, input logic fl);
      fetch_valid_ip = v;
      pc_ip          = pc;
      pc_incr_ip     = pc + 32'd4;
      instr_ip       = ins;
      stall_ip       = st;
      flush_ip       = fl;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic expect_word(input int lat, input logic [XLEN-1:0] pc, input logic [31:0] ins);
      exp_q.push_back({cyc + 16'(lat), pc, pc + 32'd4, ins});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
         tick();
      end
      check("rst_instr", 64'(instr_op), 64'(NOP));
      check("rst_valid", 64'(valid_op), 64'd0);
      check("rst_pc", 64'(pc_op), 64'd0);
      check("rst_cnt", 64'(bubble_cnt_op), 64'd0);
      check("rst_ready", 64'(fetch_ready_op), 64'd1);
      rst = 1'b0;
      idle();
   endtask

   task automatic check_drained(input string name);
      check(name, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      // stream: four back-to-back fetches, one cycle each to Q2
      do_reset();
      drive(1'b1, 32'h0, 32'h1111_0001, 1'b0, 1'b0); expect_word(1, 32'h0, 32'h1111_0001); tick();
      drive(1'b1, 32'h4, 32'h1111_0002, 1'b0, 1'b0); expect_word(1, 32'h4, 32'h1111_0002); tick();
      drive(1'b1, 32'h8, 32'h1111_0003, 1'b0, 1'b0); expect_word(1, 32'h8, 32'h1111_0003); tick();
      drive(1'b1, 32'hC, 32'h1111_0004, 1'b0, 1'b0); expect_word(1, 32'hC, 32'h1111_0004); tick();
      check("stream_valid", 64'(valid_op), 64'd1);
      check("stream_cnt", 64'(bubble_cnt_op), 64'd0);
      idle(); tick();
      check("stream_bubble_valid", 64'(valid_op), 64'd0);
      check("stream_bubble_instr", 64'(instr_op), 64'(NOP));
      check("stream_bubble_cnt", 64'(bubble_cnt_op), 64'd1);
      check_drained("stream_drained");

      // skid fill under stall, then drain on release
      do_reset();
      drive(1'b1, 32'h10, 32'h2222_0010, 1'b0, 1'b0); expect_word(1, 32'h10, 32'h2222_0010); tick();
      drive(1'b1, 32'h14, 32'h2222_0014, 1'b1, 1'b0); expect_word(2, 32'h14, 32'h2222_0014); tick();
      check("skid_ready_low", 64'(fetch_ready_op), 64'd0);
      check("skid_hold_pc", 64'(pc_op), 64'h10);
      check("skid_hold_valid", 64'(valid_op), 64'd1);
      drive(1'b0, '0, '0, 1'b1, 1'b0); tick();
      check("skid_still_held", 64'(pc_op), 64'h10);
      check("skid_ready_still_low", 64'(fetch_ready_op), 64'd0);
      idle(); tick();
      check("skid_drain_pc", 64'(pc_op), 64'h14);
      check("skid_drain_valid", 64'(valid_op), 64'd1);
      check("skid_ready_back", 64'(fetch_ready_op), 64'd1);
      check("skid_cnt", 64'(bubble_cnt_op), 64'd0);
      exp_q[0][EW-1 -: 16] = exp_q[0][EW-1 -: 16] + 16'd1;
      tick();
      check_drained("skid_drained");

      // flush beats stall while the skid entry is full
      do_reset();
      drive(1'b1, 32'h10, 32'h3333_0010, 1'b0, 1'b0); expect_word(1, 32'h10, 32'h3333_0010); tick();
      drive(1'b1, 32'h14, 32'h3333_0014, 1'b1, 1'b0); tick();
      check("fl_skid_full", 64'(fetch_ready_op), 64'd0);
      drive(1'b0, '0, '0, 1'b1, 1'b1); tick();
      check("fl_valid", 64'(valid_op), 64'd0);
      check("fl_instr", 64'(instr_op), 64'(NOP));
      check("fl_pc", 64'(pc_op), 64'd0);
      check("fl_ready", 64'(fetch_ready_op), 64'd1);
      check("fl_cnt", 64'(bubble_cnt_op), 64'd1);
      idle(); tick(); tick(); tick();
      check("fl_cnt_idle", 64'(bubble_cnt_op), 64'd4);
      check_drained("fl_drained");

      // flush discards a fetch arriving in the same cycle
      do_reset();
      drive(1'b1, 32'h1C, 32'h4444_001C, 1'b0, 1'b0); expect_word(1, 32'h1C, 32'h4444_001C); tick();
      drive(1'b1, 32'h20, 32'h4444_0020, 1'b0, 1'b1); tick();
      check("fla_valid", 64'(valid_op), 64'd0);
      check("fla_pc", 64'(pc_op), 64'd0);
      check("fla_cnt", 64'(bubble_cnt_op), 64'd1);
      idle(); tick(); tick();
      check_drained("fla_drained");

      // bubble counter saturates at all-ones
      do_reset();
      for (int i = 0; i < 14; i++) tick();
      check("sat_cnt_14", 64'(bubble_cnt_op), 64'hE);
      tick();
      check("sat_cnt_15", 64'(bubble_cnt_op), 64'hF);
      for (int i = 0; i < 5; i++) tick();
      check("sat_cnt_20", 64'(bubble_cnt_op), 64'hF);
      check_drained("final_drained");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
